udp_tx_scheduler: RTL

//   Shares one UDP_encoder among N_REQ packet sources. Arbitrates round-robin,

---
 rtl/udp_tx_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler that shares one UDP encoder among N_REQ packet sources:
// picks a requester, latches its header, sequences the encoder and reports the result.
module udp_tx_scheduler #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   req_src_port,
  input  logic [16*N_REQ-1:0]   req_dest_port,
  input  logic [16*N_REQ-1:0]   req_len,
  input  logic [N_REQ-1:0]      req_no_chksum,
  input  logic [32*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]      req_data_av,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      err,
  output logic [15:0]           chk_out,
  output logic [15:0]           enc_src_port,
  output logic [15:0]           enc_dest_port,
  output logic [15:0]           enc_len,
  output logic                  enc_no_chksum,
  output logic [31:0]           enc_data,
  output logic                  enc_data_av,
  output logic                  enc_start,
  output logic                  enc_reset,
  input  logic                  enc_fin,
  input  logic [15:0]           enc_checksum,
  output logic [2:0]            dbg_state
);

  // Handshake: a requester holds req (level) until it sees its done or err
  // pulse and drops req the cycle after; req still high in IDLE is a new request.

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REJECT = 3'd1,
    S_CLEAR  = 3'd2,
    S_START  = 3'd3,
    S_BUSY   = 3'd4,
    S_DONE   = 3'd5,
    S_ABORT  = 3'd6
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   next_rr;
  logic [CNT_W-1:0]   busy_cnt;
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  int                 arb_j;
  logic [15:0]        arb_len;
  logic               len_bad;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First set request at or after rr_ptr, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_j = (int'(rr_ptr) + k) % N_REQ;
      if (!arb_found && req[arb_j]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(arb_j);
      end
    end
  end

  assign arb_len = req_len[16*int'(arb_idx) +: 16];
  assign len_bad = (arb_len > 16'hFFF7);
  assign next_rr = IDX_W'((int'(cur_idx) + 1) % N_REQ);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (arb_found) next_state = len_bad ? S_REJECT : S_CLEAR;
      S_REJECT: next_state = S_IDLE;
      S_CLEAR:  next_state = S_START;
      S_START:  next_state = S_BUSY;
      S_BUSY: begin
        if (enc_fin)                               next_state = S_DONE;
        else if (busy_cnt == CNT_W'(TIMEOUT - 1))  next_state = S_ABORT;
      end
      S_DONE:   next_state = S_IDLE;
      S_ABORT:  next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      cur_idx       <= '0;
      busy_cnt      <= '0;
      grant         <= '0;
      done          <= '0;
      err           <= '0;
      chk_out       <= '0;
      enc_start     <= 1'b0;
      enc_reset     <= 1'b1;
      enc_src_port  <= '0;
      enc_dest_port <= '0;
      enc_len       <= '0;
      enc_no_chksum <= 1'b0;
    end else begin
      state     <= next_state;
      enc_start <= (next_state == S_START);
      // The encoder is held in reset whenever it is not actively owned.
      enc_reset <= !((next_state == S_START) || (next_state == S_BUSY));
      done      <= '0;
      err       <= '0;
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            cur_idx       <= arb_idx;
            enc_src_port  <= req_src_port[16*int'(arb_idx) +: 16];
            enc_dest_port <= req_dest_port[16*int'(arb_idx) +: 16];
            enc_len       <= arb_len;
            enc_no_chksum <= req_no_chksum[arb_idx];
            if (len_bad) err   <= onehot(arb_idx);
            else         grant <= onehot(arb_idx);
          end
        end
        S_REJECT: rr_ptr <= next_rr;
        S_START:  busy_cnt <= '0;
        S_BUSY: begin
          busy_cnt <= busy_cnt + 1'b1;
          if (next_state == S_DONE) begin
            done    <= onehot(cur_idx);
            chk_out <= enc_checksum;
            grant   <= '0;
          end else if (next_state == S_ABORT) begin
            err   <= onehot(cur_idx);
            grant <= '0;
          end
        end
        S_DONE:  rr_ptr <= next_rr;
        S_ABORT: rr_ptr <= next_rr;
        default: ;
      endcase
    end
  end

  assign enc_data    = (grant != '0) ? req_data[32*int'(cur_idx) +: 32] : 32'h0;
  assign enc_data_av = ((state == S_START) || (state == S_BUSY)) && req_data_av[cur_idx];
  assign dbg_state   = state;

endmodule
